fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Write-side pointer and flag controller for the asynchronous FIFO, sitting directly upstream of the dual-clock FIFO memory in the write-clock domain. It accepts write requests and drives the memory's write enable and write address. It publishes a Gray-coded write pointer to the read domain and derives full, almost-full, fill level and overflow from a two-flop-synchronised copy of the read-domain Gray pointer.

## Interface
- `SIZE`, 4: address width; memory depth is 2**SIZE.
- `DEPTH`, 16: memory depth; must equal 2**SIZE.
- `AF_THRESH`, 12: fill level at or above which `almost_full` asserts; range 1..DEPTH.

- `wr_clk`  in  1: write clock; sole clock of the block.
- `rst_n`  in  1: asynchronous, active-low reset.
- `wr_req`  in  1: producer requests a write this cycle.
- `ovf_clr`  in  1: clears sticky `overflow`.
- `rd_gray_ptr`  in  SIZE+1: read-domain Gray pointer, asynchronous to `wr_clk`.
- `write_en`  out  1: memory write enable (`wr_req & ~full`).
- `wr_addr`  out  SIZE: memory write address (low bits of binary write pointer).
- `wr_gray_ptr`  out  SIZE+1: registered Gray write pointer for the read domain.
- `full`  out  1: FIFO full.
- `almost_full`  out  1: level ≥ AF_THRESH.
- `wr_level`  out  SIZE+1: entries occupied, as seen from the write domain.
- `overflow`  out  1: sticky; a request was made while full.

## Operation
- Binary pointer `wbin` is SIZE+1 bits; MSB is the wrap bit. `wr_addr = wbin[SIZE-1:0]`.
- `write_en = wr_req & ~full`, combinational. On an accepted write, `wbin_next = wbin + 1`, wrapping modulo 2**(SIZE+1). Otherwise `wbin_next = wbin`.
- `wr_gray_ptr` is registered as `bin2gray(wbin_next)` and changes exactly one bit per accepted write.
- `rd_gray_ptr` passes through two flops to produce `rq2`. Only `rq2` is used in logic.
- `full_next = (bin2gray(wbin_next) == {~rq2[SIZE:SIZE-1], rq2[SIZE-2:0]})`, registered.
- `wr_level_next = wbin_next − gray2bin(rq2)`, modulo 2**(SIZE+1), registered. Range is 0..DEPTH.
- `almost_full` is registered from `wr_level_next >= AF_THRESH`.
- Overflow:
  - `wr_req & full` sets `overflow` on the next edge.
  - `ovf_clr` clears it.
  - Set wins over clear in the same cycle.
  - A rejected request never moves the pointer or asserts `write_en`.
- Reset: `wbin`, `wr_gray_ptr`, both sync stages, `full`, `almost_full`, `wr_level` and `overflow` go to 0 immediately on `rst_n` low, with no clock required. `wr_addr` is 0 and `write_en` is 0 while in reset.

## Timing
- Write acceptance: zero-latency enable. The memory captures `data_in` at `wr_addr` on the same `wr_clk` edge that advances `wbin`.
- `full` asserts on the edge of the write that fills the last entry. A request in the following cycle is rejected.
- Read-pointer propagation:
  - A `rd_gray_ptr` change stable before edge N reaches `rq2` at edge N+1.
  - `full`, `wr_level` and `almost_full` reflect it at edge N+2.
- Flags are pessimistic: stale read pointers can only overstate occupancy, never cause overwrite.
- Simultaneous write and read-pointer change: both are accounted for in the same `wr_level_next` computation.
- Reset release is synchronous to operation only in that the first accepted write is on the first edge with `rst_n` high.

## Configuration
- `FIFO_WR_LEVEL_EN` defined: `wr_level` and `almost_full` are computed as above, including the `gray2bin` conversion and subtractor.
- `FIFO_WR_LEVEL_EN` undefined:
  - `wr_level` and `almost_full` are tied 0.
  - The `gray2bin` conversion and subtractor are omitted.
  - `full`, `overflow`, pointers and timing are unchanged.

## Structure
- Shared package `fifo_pkg` holds:
  - constants `FIFO_SIZE`, `FIFO_DEPTH`, `FIFO_WIDTH`;
  - functions `bin2gray` and `gray2bin`, parameterised on SIZE+1 bits.
- The read-side controller reuses the same package.
- One sub-module: `sync_2ff`, a width-parameterised two-flop synchroniser with async active-low reset. It is instantiated once for `rd_gray_ptr` and reused by the read side.

## Test plan
- Reset: hold `rst_n`=0 with `wr_req`=1 → `write_en`=0 and `wr_addr`=0, all outputs 0.
- Fill: `rd_gray_ptr`=0, 16 consecutive `wr_req` → `write_en` high 16 cycles, `wr_addr` 0..15. `almost_full` rises with the 12th write and `full` with the 16th; `wr_level`=16.
- Overflow: 17th `wr_req` while full → `write_en`=0, `wr_addr` stays 0, `overflow`=1 sticky. It clears one edge after `ovf_clr`=1, and is not cleared if `wr_req & full` coincides.
- Drain release: from full, set `rd_gray_ptr`=6 (binary 4) before edge N → `full`=0, `almost_full`=1 and `wr_level`=12 at edge N+2, not earlier.
- Wrap: 40 writes with the read pointer following 8 behind → `wr_addr` wraps 15→0 twice. `wr_gray_ptr` changes one bit per write; the wrap bit of `wbin` toggles at writes 16 and 32. `full` is never set.
- Mid-operation reset: pull `rst_n` low between edges at `wr_level`=9 → all outputs 0 before the next edge. The first write after release lands at `wr_addr`=0.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and Gray-code helpers for the write-side
//                and read-side controllers of the asynchronous FIFO.
//                The helpers work on FIFO_SIZE+1 bit pointers. FIFO_SIZE
//                address bits plus one wrap bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_SIZE  = 4;
    localparam int FIFO_DEPTH = 1 << FIFO_SIZE;
    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_PTR_W = FIFO_SIZE + 1;

    typedef logic [FIFO_PTR_W-1:0] fifo_ptr_t;

    function automatic fifo_ptr_t bin2gray(input fifo_ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above its position.
    function automatic fifo_ptr_t gray2bin(input fifo_ptr_t g);
        fifo_ptr_t b;
        b[FIFO_PTR_W-1] = g[FIFO_PTR_W-1];
        for (int i = FIFO_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Width-parameterised two-flop synchroniser with asynchronous
//                active-low reset. Intended for Gray-coded buses, where only
//                one bit changes at a time, so a multi-bit capture is safe.
//  Ports       : clk    - destination clock
//                rst_n  - asynchronous active-low reset
//                i_d    - asynchronous input bus
//                o_q    - synchronised output (two destination edges later)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_ctrl
//  Description : Write-side pointer and flag controller of the asynchronous
//                FIFO. Drives memory write enable/address, publishes a Gray
//                write pointer and derives full / almost-full / level /
//                overflow from a synchronised copy of the read Gray pointer.
//  Options     : FIFO_WR_LEVEL_EN - when defined, wr_level and almost_full
//                are computed; otherwise both are tied low and the Gray-to-
//                binary converter and subtractor are not built.
//  Ports       : wr_clk       - write clock
//                rst_n        - asynchronous active-low reset
//                wr_req       - producer write request
//                ovf_clr      - clears sticky overflow
//                rd_gray_ptr  - read-domain Gray pointer (asynchronous)
//                write_en     - memory write enable
//                wr_addr      - memory write address
//                wr_gray_ptr  - registered Gray write pointer
//                full         - FIFO full
//                almost_full  - level >= AF_THRESH
//                wr_level     - occupancy as seen from the write domain
//                overflow     - sticky: request made while full
//  Notes       : SIZE must equal fifo_pkg::FIFO_SIZE (the Gray helpers are
//                sized from the package); DEPTH must equal 2**SIZE.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int SIZE      = FIFO_SIZE,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int AF_THRESH = 12
) (
    input  logic          wr_clk,
    input  logic          rst_n,
    input  logic          wr_req,
    input  logic          ovf_clr,
    input  logic [SIZE:0] rd_gray_ptr,
    output logic          write_en,
    output logic [SIZE-1:0] wr_addr,
    output logic [SIZE:0] wr_gray_ptr,
    output logic          full,
    output logic          almost_full,
    output logic [SIZE:0] wr_level,
    output logic          overflow
);

    // A mis-configured instance never accepts a write, so the error shows up
    // on the first transfer rather than as silent corruption.
    localparam bit c_cfg_ok = (SIZE == FIFO_SIZE) && (DEPTH == (1 << SIZE)) &&
                              (AF_THRESH >= 1) && (AF_THRESH <= DEPTH);

    logic [SIZE:0] r_wbin;
    logic [SIZE:0] r_wgray;
    logic          r_full;
    logic          r_ovf;

    logic [SIZE:0] w_rq2;
    logic [SIZE:0] w_wbin_next;
    logic [SIZE:0] w_wgray_next;
    logic          w_full_next;
    logic          w_write_en;

    sync_2ff #(
        .WIDTH (SIZE + 1)
    ) u_rd_sync (
        .clk   (wr_clk),
        .rst_n (rst_n),
        .i_d   (rd_gray_ptr),
        .o_q   (w_rq2)
    );

    // rst_n gates the enable so a request held through reset never writes.
    assign w_write_en   = wr_req & ~r_full & rst_n & c_cfg_ok;
    assign w_wbin_next  = r_wbin + {{SIZE{1'b0}}, w_write_en};
    assign w_wgray_next = bin2gray(w_wbin_next);

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that is the two MSBs inverted, rest equal.
    assign w_full_next  = (w_wgray_next == {~w_rq2[SIZE:SIZE-1], w_rq2[SIZE-2:0]});

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            r_full  <= w_full_next;
            // Set takes priority over clear.
            if (wr_req && r_full) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    localparam logic [SIZE:0] c_af_thresh = (SIZE + 1)'(AF_THRESH);

    logic [SIZE:0] r_level;
    logic          r_af;
    logic [SIZE:0] w_rbin;
    logic [SIZE:0] w_level_next;

    // Uses the post-write pointer so a write and a read-pointer change in
    // the same cycle are both reflected in one update.
    assign w_rbin       = gray2bin(w_rq2);
    assign w_level_next = w_wbin_next - w_rbin;

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            r_af    <= 1'b0;
        end else begin
            r_level <= w_level_next;
            r_af    <= (w_level_next >= c_af_thresh);
        end
    end

    assign wr_level    = r_level;
    assign almost_full = r_af;
`else
    assign wr_level    = '0;
    assign almost_full = 1'b0;
`endif

    assign write_en    = w_write_en;
    assign wr_addr     = r_wbin[SIZE-1:0];
    assign wr_gray_ptr = r_wgray;
    assign full        = r_full;
    assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_ctrl
//  Description : Self-checking bench for fifo_wr_ctrl. An occupancy-count
//                model predicts every output each cycle; directed phases
//                (reset, fill, overflow, drain, wrap, mid-run reset) add
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ctrl;

    localparam int SZ  = 4;
    localparam int MOD = 32;   // pointer space, 2**(SZ+1)

    logic          wr_clk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          wr_req = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [SZ:0]   rd_gray_ptr = '0;
    logic          write_en;
    logic [SZ-1:0] wr_addr;
    logic [SZ:0]   wr_gray_ptr;
    logic          full;
    logic          almost_full;
    logic [SZ:0]   wr_level;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    fifo_wr_ctrl #(
        .SIZE      (4),
        .DEPTH     (16),
        .AF_THRESH (12)
    ) dut (
        .wr_clk      (wr_clk),
        .rst_n       (rst_n),
        .wr_req      (wr_req),
        .ovf_clr     (ovf_clr),
        .rd_gray_ptr (rd_gray_ptr),
        .write_en    (write_en),
        .wr_addr     (wr_addr),
        .wr_gray_ptr (wr_gray_ptr),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .overflow    (overflow)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tb_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Inverse by search over the pointer space.
    function automatic int tb_bin(input int g);
        for (int b = 0; b < MOD; b++) begin
            if (tb_gray(b) == g) return b;
        end
        return 0;
    endfunction

    // ---------------- occupancy model ----------------
    int m_wcnt  = 0;   // accepted writes, modulo MOD
    int m_rd1   = 0;   // read pointer seen one edge ago
    int m_rd2   = 0;   // read pointer seen two edges ago
    int m_level = 0;
    bit m_full  = 0;
    bit m_af    = 0;
    bit m_ovf   = 0;
    int m_last_acc = 0;
    bit m_rst_seen = 1;

    always @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wcnt = 0; m_rd1 = 0; m_rd2 = 0; m_level = 0;
            m_full = 0; m_af = 0; m_ovf = 0; m_last_acc = 0;
            m_rst_seen = 1;
        end else begin
            m_last_acc = (wr_req && !m_full) ? 1 : 0;
            if (wr_req && m_full) m_ovf = 1;
            else if (ovf_clr)     m_ovf = 0;
            m_wcnt  = (m_wcnt + m_last_acc) % MOD;
            m_level = (m_wcnt - m_rd2 + MOD) % MOD;
            m_full  = (m_level == 16);
            m_af    = (m_level >= 12);
            m_rd2   = m_rd1;
            m_rd1   = tb_bin(int'(rd_gray_ptr));
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [SZ:0] prev_gray = '0;

    always @(negedge wr_clk) begin
        chk("write_en", write_en, (rst_n && wr_req && !m_full) ? 1 : 0);
        chk("wr_addr", wr_addr, m_wcnt % 16);
        chk("wr_gray_ptr", wr_gray_ptr, tb_gray(m_wcnt));
        chk("full", full, m_full);
        chk("overflow", overflow, m_ovf);
`ifdef FIFO_WR_LEVEL_EN
        chk("wr_level", wr_level, m_level);
        chk("almost_full", almost_full, m_af);
`else
        chk("wr_level", wr_level, 0);
        chk("almost_full", almost_full, 0);
`endif
        if (!m_rst_seen) begin
            chk("gray_step", $countones(prev_gray ^ wr_gray_ptr), m_last_acc);
        end
        m_rst_seen = 0;
        prev_gray  = wr_gray_ptr;
    end

    task automatic to_drive();
        @(negedge wr_clk);
        #1;
    endtask

    task automatic chk_level(input string name, input int exp);
`ifdef FIFO_WR_LEVEL_EN
        chk(name, wr_level, exp);
`else
        chk(name, wr_level, 0);
`endif
    endtask

    task automatic chk_af(input string name, input int exp);
`ifdef FIFO_WR_LEVEL_EN
        chk(name, almost_full, exp);
`else
        chk(name, almost_full, 0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;

        // Reset held with a pending request.
        wr_req = 1'b1;
        repeat (3) @(negedge wr_clk);
        chk("rst_write_en", write_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_outputs", {wr_gray_ptr, full, almost_full, wr_level, overflow}, 0);

        // Fill: release between edges, request held for 16 edges.
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge wr_clk);
            chk("fill_addr", wr_addr, k % 16);
            chk_level("fill_level", k);
            chk_af("fill_af", (k >= 12) ? 1 : 0);
            chk("fill_full", full, (k == 16) ? 1 : 0);
        end
        chk("fill_we_low", write_en, 0);

        // 17th request while full.
        @(negedge wr_clk);
        chk("ovf_set", overflow, 1);
        chk("ovf_addr", wr_addr, 0);
        #1 wr_req = 1'b0;
        @(negedge wr_clk);
        chk("ovf_sticky", overflow, 1);

        // Clear coinciding with a rejected request: set wins.
        #1 begin wr_req = 1'b1; ovf_clr = 1'b1; end
        @(negedge wr_clk);
        chk("ovf_set_wins", overflow, 1);
        #1 wr_req = 1'b0;
        @(negedge wr_clk);
        chk("ovf_cleared", overflow, 0);
        #1 ovf_clr = 1'b0;

        // Drain release: read pointer binary 4 (Gray 6) before edge N.
        rd_gray_ptr = 5'd6;
        @(negedge wr_clk);
        chk("drain_n_full", full, 1);
        @(negedge wr_clk);
        chk("drain_n1_full", full, 1);
        chk_level("drain_n1_level", 16);
        @(negedge wr_clk);
        chk("drain_n2_full", full, 0);
        chk_af("drain_n2_af", 1);
        chk_level("drain_n2_level", 12);

        // Wrap: 40 writes, read pointer following 8 behind.
        wc = 16;
        for (int i = 0; i < 40; i++) begin
            #1;
            wr_req = 1'b1;
            rd_gray_ptr = (SZ+1)'(tb_gray((wc - 8 + MOD) % MOD));
            @(negedge wr_clk);
            wc = (wc + 1) % MOD;
            chk("wrap_no_full", full, 0);
        end
        chk("wrap_addr_end", wr_addr, 8);
        chk("wrap_gray_end", wr_gray_ptr, 5'b10100);

        // Settle at level 9, then reset mid-run between edges.
        #1;
        wr_req = 1'b0;
        rd_gray_ptr = (SZ+1)'(tb_gray((wc - 9 + MOD) % MOD));
        repeat (3) @(negedge wr_clk);
        chk_level("pre_rst_level", 9);
        #1;
        wr_req = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_write_en", write_en, 0);
        chk("midrst_addr", wr_addr, 0);
        chk("midrst_outputs", {wr_gray_ptr, full, almost_full, wr_level, overflow}, 0);
        rd_gray_ptr = '0;
        @(negedge wr_clk);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_we", write_en, 1);
        chk("post_rst_addr", wr_addr, 0);
        @(negedge wr_clk);
        chk("post_rst_addr1", wr_addr, 1);
        chk_level("post_rst_level", 1);
        #1 wr_req = 1'b0;
        repeat (3) @(negedge wr_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
